// File: rtl/bsg_dmc_pkg.sv
// Shared types for the DMC user-interface responder.
// Command encodings follow the usual UI convention.
package bsg_dmc_pkg;

  typedef enum logic [2:0] {
    WR = 3'b000,
    RD = 3'b001,
    WP = 3'b011,
    RP = 3'b101
  } app_cmd_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with per-byte write enables.
// Read data appears one cycle after the address is applied.
module bsg_mem_1rw_sync_mask_write_byte #(
  parameter int els_p        = 512,
  parameter int data_width_p = 32,
  localparam int addr_w_lp   = $clog2(els_p),
  localparam int mask_w_lp   = data_width_p / 8
) (
  input  logic                    clk_i,
  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_w_lp-1:0]    addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [mask_w_lp-1:0]    write_mask_i,
  output logic [data_width_p-1:0] data_o
);

  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < mask_w_lp; i++) begin
        if (write_mask_i[i]) begin
          mem_q[addr_i][i*8 +: 8] <= data_i[i*8 +: 8];
        end
      end
    end
    if (v_i & ~w_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_dmc_ui_responder.sv
// Behavioural DRAM-controller UI responder: burst storage,
// fixed read latency, refresh/ZQ/self-refresh handshakes.
module bsg_dmc_ui_responder
  import bsg_dmc_pkg::*;
#(
  parameter int ui_addr_width_p   = 28,
  parameter int ui_data_width_p   = 32,
  parameter int ui_burst_length_p = 8,
  parameter int mem_els_p         = 64,
  parameter int rd_latency_p      = 4,
  parameter int init_cycles_p     = 16,
  parameter int ref_cycles_p      = 8,
  localparam int mask_w_lp        = ui_data_width_p / 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [ui_addr_width_p-1:0] app_addr_i,
  input  app_cmd_e                   app_cmd_i,
  input  logic                       app_en_i,
  output logic                       app_rdy_o,
  input  logic                       app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0] app_wdf_data_i,
  input  logic [mask_w_lp-1:0]       app_wdf_mask_i,
  input  logic                       app_wdf_end_i,
  output logic                       app_wdf_rdy_o,
  output logic                       app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0] app_rd_data_o,
  output logic                       app_rd_data_end_o,
  input  logic                       app_ref_req_i,
  output logic                       app_ref_ack_o,
  input  logic                       app_zq_req_i,
  output logic                       app_zq_ack_o,
  input  logic                       app_sr_req_i,
  output logic                       app_sr_active_o,
  output logic                       init_calib_complete_o,
  output logic                       cmd_err_o
);

  localparam int bl_lg_lp  = $clog2(ui_burst_length_p);
  localparam int els_lg_lp = $clog2(mem_els_p);
  localparam int maw_lp    = bl_lg_lp + els_lg_lp;
  localparam int depth_lp  = mem_els_p * ui_burst_length_p;

  localparam logic [15:0] init_last_lp  = 16'(init_cycles_p - 1);
  localparam logic [15:0] ref_last_lp   = 16'(ref_cycles_p - 1);
  localparam logic [15:0] burst_last_lp = 16'(ui_burst_length_p - 1);
  localparam logic [15:0] rwait_last_lp =
    (rd_latency_p > 1) ? 16'(rd_latency_p - 2) : 16'd0;
  localparam logic [bl_lg_lp-1:0] beat0_lp = '0;

  typedef enum logic [2:0] {
    INIT, IDLE, WDATA, RWAIT, RDATA, MAINT, SR
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [els_lg_lp-1:0]   idx_q, idx_d;
  logic                   err_q, err_d;
  logic                   zq_q, zq_d;

  logic                   accept;
  logic                   maint_done;
  logic [els_lg_lp-1:0]   app_idx;
  logic [bl_lg_lp-1:0]    beat_q;
  logic                   mem_v, mem_w;
  logic [maw_lp-1:0]      mem_addr;
  logic                   unused_addr;

  assign app_idx     = app_addr_i[bl_lg_lp +: els_lg_lp];
  assign beat_q      = cnt_q[bl_lg_lp-1:0];
  assign unused_addr = ^app_addr_i;

  assign app_rdy_o = (state_q == IDLE) & ~app_ref_req_i
                   & ~app_zq_req_i & ~app_sr_req_i;
  assign accept    = app_en_i & app_rdy_o;
  assign maint_done = (state_q == MAINT) & (cnt_q == ref_last_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      zq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      zq_q    <= zq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    zq_d     = zq_q;
    mem_v    = 1'b0;
    mem_w    = 1'b0;
    mem_addr = {idx_q, beat_q};
    unique case (state_q)
      INIT: begin
        if (cnt_q == init_last_lp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (app_sr_req_i) begin
          state_d = SR;
        end else if (app_ref_req_i) begin
          state_d = MAINT;
          zq_d    = 1'b0;
        end else if (app_zq_req_i) begin
          state_d = MAINT;
          zq_d    = 1'b1;
        end else if (accept) begin
          idx_d = app_idx;
          case (app_cmd_i)
            WR, WP: state_d = WDATA;
            RD, RP: begin
              if (rd_latency_p == 1) begin
                state_d  = RDATA;
                mem_v    = 1'b1;
                mem_addr = {app_idx, beat0_lp};
              end else begin
                state_d = RWAIT;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      WDATA: begin
        if (app_wdf_wren_i) begin
          mem_v = 1'b1;
          mem_w = 1'b1;
          cnt_d = cnt_q + 16'd1;
          if (app_wdf_end_i != (cnt_q == burst_last_lp)) begin
            err_d = 1'b1;
          end
          if (cnt_q == burst_last_lp) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      RWAIT: begin
        if (cnt_q == rwait_last_lp) begin
          // Prefetch beat 0 so it lands on the first RDATA cycle.
          state_d  = RDATA;
          cnt_d    = '0;
          mem_v    = 1'b1;
          mem_addr = {idx_q, beat0_lp};
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RDATA: begin
        if (cnt_q == burst_last_lp) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d    = cnt_q + 16'd1;
          mem_v    = 1'b1;
          mem_addr = {idx_q, beat_q + bl_lg_lp'(1)};
        end
      end
      MAINT: begin
        if (maint_done) begin
          cnt_d = '0;
          // A ZQ raised alongside refresh follows without an IDLE gap.
          if (!zq_q && app_zq_req_i && !app_sr_req_i) begin
            zq_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SR: begin
        if (!app_sr_req_i) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  bsg_mem_1rw_sync_mask_write_byte #(
    .els_p        (depth_lp),
    .data_width_p (ui_data_width_p)
  ) mem (
    .clk_i        (clk_i),
    .v_i          (mem_v & reset_n_i),
    .w_i          (mem_w),
    .addr_i       (mem_addr),
    .data_i       (app_wdf_data_i),
    .write_mask_i (~app_wdf_mask_i),
    .data_o       (app_rd_data_o)
  );

  assign app_wdf_rdy_o         = (state_q == WDATA);
  assign app_rd_data_valid_o   = (state_q == RDATA);
  assign app_rd_data_end_o     = (state_q == RDATA)
                               & (cnt_q == burst_last_lp);
  assign app_ref_ack_o         = maint_done & ~zq_q;
  assign app_zq_ack_o          = maint_done & zq_q;
  assign app_sr_active_o       = (state_q == SR);
  assign init_calib_complete_o = (state_q != INIT);
  assign cmd_err_o             = err_q;

endmodule

// File: tb/tb_bsg_dmc_ui_responder.sv
// Randomized self-checking bench for bsg_dmc_ui_responder.
module tb_bsg_dmc_ui_responder;
  import bsg_dmc_pkg::*;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int BL = 8;
  localparam int NB = 64;
  localparam int RL = 4;
  localparam int IC = 16;
  localparam int RC = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] app_addr;
  app_cmd_e      app_cmd;
  logic          app_en, app_rdy;
  logic          wren, wdf_rdy, wend;
  logic [DW-1:0] wdata;
  logic [3:0]    wmask;
  logic          rvalid, rend;
  logic [DW-1:0] rdata;
  logic          ref_req, ref_ack, zq_req, zq_ack;
  logic          sr_req, sr_active, calib, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem_m [NB*BL];
  bit            wr_m  [NB];
  logic [DW-1:0] bd    [BL];
  logic [3:0]    bm    [BL];

  bsg_dmc_ui_responder dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .app_addr_i            (app_addr),
    .app_cmd_i             (app_cmd),
    .app_en_i              (app_en),
    .app_rdy_o             (app_rdy),
    .app_wdf_wren_i        (wren),
    .app_wdf_data_i        (wdata),
    .app_wdf_mask_i        (wmask),
    .app_wdf_end_i         (wend),
    .app_wdf_rdy_o         (wdf_rdy),
    .app_rd_data_valid_o   (rvalid),
    .app_rd_data_o         (rdata),
    .app_rd_data_end_o     (rend),
    .app_ref_req_i         (ref_req),
    .app_ref_ack_o         (ref_ack),
    .app_zq_req_i          (zq_req),
    .app_zq_ack_o          (zq_ack),
    .app_sr_req_i          (sr_req),
    .app_sr_active_o       (sr_active),
    .init_calib_complete_o (calib),
    .cmd_err_o             (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int bidx(input logic [AW-1:0] a);
    return (int'(a) / BL) % NB;
  endfunction

  task automatic release_and_time(input string nm);
    int n;
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!calib && n < 100);
    n_checks++;
    if (n != IC) begin
      n_fail++;
      $display("FAIL %s calib_delay got=%0d exp=%0d", nm, n, IC);
    end
  endtask

  task automatic issue_cmd(input app_cmd_e c, input logic [AW-1:0] a);
    int n;
    app_cmd  = c;
    app_addr = a;
    app_en   = 1'b1;
    #1;
    n = 0;
    while (!app_rdy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept timeout addr=%h", a);
    end
    tick();
    app_en = 1'b0;
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input app_cmd_e c,
                             input int ref_beat, input int bad_beat);
    int w;
    issue_cmd(c, a);
    for (int b = 0; b < BL; b++) begin
      wren  = 1'b1;
      wdata = bd[b];
      wmask = bm[b];
      wend  = (b == BL-1) ^ (b == bad_beat);
      if (b == ref_beat) ref_req = 1'b1;
      #1;
      n_checks++;
      if (wdf_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL wdf_rdy beat=%0d got=%b exp=1", b, wdf_rdy);
      end
      tick();
      w = bidx(a) * BL + b;
      for (int k = 0; k < 4; k++)
        if (!bm[b][k]) mem_m[w][k*8 +: 8] = bd[b][k*8 +: 8];
    end
    wr_m[bidx(a)] = 1'b1;
    wren = 1'b0;
    wend = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input app_cmd_e c);
    int lat;
    logic [DW-1:0] exp_d;
    issue_cmd(c, a);
    lat = 1;
    while (!rvalid && lat < 50) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != RL) begin
      n_fail++;
      $display("FAIL rd_latency addr=%h got=%0d exp=%0d", a, lat, RL);
    end
    for (int b = 0; b < BL; b++) begin
      exp_d = mem_m[bidx(a) * BL + b];
      n_checks++;
      if (rvalid !== 1'b1 || rend !== (b == BL-1) ||
          (wr_m[bidx(a)] && rdata !== exp_d)) begin
        n_fail++;
        $display("FAIL rd_beat %0d addr=%h got v=%b e=%b d=%h exp v=1 e=%b d=%h",
                 b, a, rvalid, rend, rdata, b == BL-1, exp_d);
      end
      tick();
    end
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_burst got v=%b exp=0", rvalid);
    end
  endtask

  task automatic test_reset();
    logic [8:0] o;
    reset_n = 1'b0;
    repeat (3) tick();
    o = {app_rdy, wdf_rdy, rvalid, rend, ref_ack, zq_ack,
         sr_active, calib, cmd_err};
    n_checks++;
    if (o !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0", o);
    end
    release_and_time("reset");
  endtask

  task automatic test_basic();
    for (int b = 0; b < BL; b++) begin
      bd[b] = 32'hA0 + b;
      bm[b] = 4'h0;
    end
    write_burst(28'h40, WR, -1, -1);
    read_burst(28'h40, RD);
  endtask

  task automatic test_mask();
    for (int b = 0; b < BL; b++) begin
      bd[b] = 32'h1111_1111;
      bm[b] = 4'h0;
    end
    write_burst(28'h0, WR, -1, -1);
    for (int b = 0; b < BL; b++) begin
      bd[b] = 32'h2222_2222;
      bm[b] = 4'b1010;
    end
    write_burst(28'h0, WP, -1, -1);
    read_burst(28'h0, RP);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 10; i++) begin
      a = AW'($urandom);
      if (!wr_m[bidx(a)] || $urandom_range(0, 1) == 1) begin
        for (int b = 0; b < BL; b++) begin
          bd[b] = $urandom;
          bm[b] = wr_m[bidx(a)] ? 4'($urandom) : 4'h0;
        end
        write_burst(a, $urandom_range(0, 1) ? WR : WP, -1, -1);
      end
      read_burst(a, $urandom_range(0, 1) ? RD : RP);
    end
  endtask

  task automatic test_idle_wdf();
    wren  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    wmask = 4'h0;
    wend  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (wdf_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_wdf_rdy got=%b exp=0", wdf_rdy);
      end
    end
    wren = 1'b0;
    wend = 1'b0;
    read_burst(28'h40, RD);
  endtask

  task automatic test_refresh();
    int n;
    for (int b = 0; b < BL; b++) begin
      bd[b] = 32'h5A00_0000 | b;
      bm[b] = 4'h0;
    end
    write_burst(28'h80, WR, 3, -1);
    n = 0;
    while (!ref_ack && n < 60) begin
      n_checks++;
      if (app_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL ref_rdy got=%b exp=0", app_rdy);
      end
      tick();
      n++;
    end
    n_checks++;
    if (n != RC) begin
      n_fail++;
      $display("FAIL ref_ack_delay got=%0d exp=%0d", n, RC);
    end
    ref_req = 1'b0;
    tick();
    n_checks++;
    if (ref_ack !== 1'b0 || app_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL ref_after got ack=%b rdy=%b exp ack=0 rdy=1",
               ref_ack, app_rdy);
    end
    read_burst(28'h80, RD);
  endtask

  task automatic test_ref_zq();
    int n;
    ref_req = 1'b1;
    zq_req  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      n_checks++;
      if (zq_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL zq_before_ref got=%b exp=0", zq_ack);
      end
    end while (!ref_ack && n < 60);
    n_checks++;
    if (n != RC) begin
      n_fail++;
      $display("FAIL refzq_ref_delay got=%0d exp=%0d", n, RC);
    end
    ref_req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      n_checks++;
      if (ref_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL ref_ack_repeat got=%b exp=0", ref_ack);
      end
    end while (!zq_ack && n < 60);
    n_checks++;
    if (n != RC) begin
      n_fail++;
      $display("FAIL refzq_zq_gap got=%0d exp=%0d", n, RC);
    end
    zq_req = 1'b0;
    tick();
    n_checks++;
    if (zq_ack !== 1'b0 || app_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL zq_after got ack=%b rdy=%b exp ack=0 rdy=1",
               zq_ack, app_rdy);
    end
  endtask

  task automatic test_wdf_end_err();
    n_checks++;
    if (cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pre got=%b exp=0", cmd_err);
    end
    for (int b = 0; b < BL; b++) begin
      bd[b] = 32'hC0DE_0000 | (b << 4);
      bm[b] = 4'h0;
    end
    write_burst(28'h100, WR, -1, 5);
    n_checks++;
    if (cmd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_wdf_end got=%b exp=1", cmd_err);
    end
    read_burst(28'h100, RD);
  endtask

  task automatic test_bad_cmd_sr();
    issue_cmd(app_cmd_e'(3'b111), 28'h40);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rvalid !== 1'b0 || wdf_rdy !== 1'b0 || cmd_err !== 1'b1) begin
        n_fail++;
        $display("FAIL bad_cmd got v=%b wr=%b err=%b exp 0 0 1",
                 rvalid, wdf_rdy, cmd_err);
      end
      tick();
    end
    sr_req   = 1'b1;
    app_en   = 1'b1;
    app_cmd  = RD;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (sr_active !== 1'b1 || app_rdy !== 1'b0 || rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL sr_hold got act=%b rdy=%b v=%b exp 1 0 0",
                 sr_active, app_rdy, rvalid);
      end
    end
    app_en = 1'b0;
    sr_req = 1'b0;
    tick();
    n_checks++;
    if (sr_active !== 1'b0 || app_rdy !== 1'b1 || cmd_err !== 1'b1) begin
      n_fail++;
      $display("FAIL sr_exit got act=%b rdy=%b err=%b exp 0 1 1",
               sr_active, app_rdy, cmd_err);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    issue_cmd(RD, 28'h40);
    n = 0;
    while (!rvalid && n < 50) begin
      tick();
      n++;
    end
    tick();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== mem_m[bidx(28'h40) * BL + 1]) begin
      n_fail++;
      $display("FAIL mid_read_beat2 got v=%b d=%h exp v=1 d=%h",
               rvalid, rdata, mem_m[bidx(28'h40) * BL + 1]);
    end
    reset_n = 1'b0;
    tick();
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got=%b exp=0", rvalid);
    end
    tick();
    n_checks++;
    if (calib !== 1'b0 || cmd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clear got calib=%b err=%b exp 0 0", calib, cmd_err);
    end
    release_and_time("mid_read");
    read_burst(28'h40, RD);
  endtask

  initial begin
    reset_n  = 1'b0;
    app_addr = '0;
    app_cmd  = WR;
    app_en   = 1'b0;
    wren     = 1'b0;
    wdata    = '0;
    wmask    = '0;
    wend     = 1'b0;
    ref_req  = 1'b0;
    zq_req   = 1'b0;
    sr_req   = 1'b0;
    for (int i = 0; i < NB; i++) wr_m[i] = 1'b0;
    for (int i = 0; i < NB*BL; i++) mem_m[i] = '0;
    test_reset();
    test_basic();
    test_mask();
    test_random();
    test_idle_wdf();
    test_refresh();
    test_ref_zq();
    test_wdf_end_err();
    test_bad_cmd_sr();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
